// File: rtl/adder_8bit_pkg.sv
// Shared width constant and word type for the registered 8-bit ripple-carry adder.
package adder_8bit_pkg;

  localparam int ADDER_W = 8;

  typedef logic [ADDER_W-1:0] add_word_t;

endpackage : adder_8bit_pkg

// File: rtl/full_adder.sv
// One-bit full-adder cell; chained by adder_8bit to form the ripple-carry core.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;

  assign w_p = x ^ y;
  assign s   = w_p ^ ci;
  assign co  = (x & y) | (ci & w_p);

endmodule : full_adder

// File: rtl/adder_8bit.sv
// Registered 8-bit ripple-carry adder with carry-in/out and a one-cycle valid flag.
// Optional signed-overflow output is enabled by defining ADDER_8BIT_OVF_EN.
module adder_8bit
  import adder_8bit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [ADDER_W-1:0]  a,
  input  logic [ADDER_W-1:0]  b,
  input  logic                cin,
  output logic [ADDER_W-1:0]  out,
  output logic                cout,
  output logic                out_valid
`ifdef ADDER_8BIT_OVF_EN
  ,
  output logic                ovf
`endif
);

  logic [ADDER_W:0] w_c;
  add_word_t        w_sum;

  add_word_t        r_out;
  logic             r_cout;
  logic             r_out_valid;

  assign w_c[0] = cin;

  // c[8] is the slow path: it ripples through every cell from cin/a[0].
  for (genvar g = 0; g < ADDER_W; g++) begin : g_cell
    full_adder u_fa (
      .x  (a[g]),
      .y  (b[g]),
      .ci (w_c[g]),
      .s  (w_sum[g]),
      .co (w_c[g+1])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_cout <= 1'b0;
    end else if (in_valid) begin
      r_out  <= w_sum;
      r_cout <= w_c[ADDER_W];
    end
  end

  // The valid flag follows in_valid, so it pulses once per accepted input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
    end
  end

  assign out       = r_out;
  assign cout      = r_cout;
  assign out_valid = r_out_valid;

`ifdef ADDER_8BIT_OVF_EN
  logic r_ovf;

  // Carries into and out of the sign bit disagree exactly on signed overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (in_valid) begin
      r_ovf <= w_c[ADDER_W-1] ^ w_c[ADDER_W];
    end
  end

  assign ovf = r_ovf;
`endif

endmodule : adder_8bit

// File: tb/tb_adder_8bit.sv
// Self-checking bench for adder_8bit: directed steps plus random traffic checked against an arithmetic model.
// Build with ADDER_8BIT_OVF_EN defined to also check the overflow output.
module tb_adder_8bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic [7:0] out;
  logic       cout;
  logic       out_valid;
`ifdef ADDER_8BIT_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: what the outputs must show after the most recent edge.
  logic [7:0] exp_out   = '0;
  logic       exp_cout  = 1'b0;
  logic       exp_valid = 1'b0;
  logic       exp_ovf   = 1'b0;

  adder_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out       (out),
    .cout      (cout),
    .out_valid (out_valid)
`ifdef ADDER_8BIT_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
    end
  endtask

  // Model update from plain integer arithmetic on the values applied at this edge.
  task automatic model_edge(input logic r, input logic v, input logic [7:0] x,
                            input logic [7:0] y, input logic c);
    int unsigned usum;
    int          ssum;
    if (r) begin
      exp_out   = 8'h00;
      exp_cout  = 1'b0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
    end else if (v) begin
      usum      = int'(x) + int'(y) + int'(c);
      exp_out   = 8'(usum % 256);
      exp_cout  = (usum >= 256);
      ssum      = int'($signed(x)) + int'($signed(y)) + int'(c);
      exp_ovf   = (ssum > 127) || (ssum < -128);
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_byte({tag, ".out"}, out, exp_out);
    check_bit({tag, ".cout"}, cout, exp_cout);
    check_bit({tag, ".out_valid"}, out_valid, exp_valid);
`ifdef ADDER_8BIT_OVF_EN
    check_bit({tag, ".ovf"}, ovf, exp_ovf);
`endif
  endtask

  // Apply one cycle of inputs, advance past the edge, then compare.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [7:0] x, input logic [7:0] y, input logic c);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    a        = x;
    b        = y;
    cin      = c;
    @(posedge clk);
    model_edge(r, v, x, y, c);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;

    // Reset holds every output at zero, even with valid inputs present.
    step("reset0", 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    step("reset1", 1'b1, 1'b1, 8'hAA, 8'h55, 1'b1);

    // First accepted input after reset, then its valid pulse ends.
    step("one_plus_one", 1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
    check_byte("one_plus_one.const", out, 8'h02);
    step("idle_after_first", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Back-to-back sweep: out_valid must stay high throughout.
    for (int i = 0; i <= 86; i++) begin
      step("sweep", 1'b0, 1'b1, 8'(i), 8'(i + 1), 1'b0);
      check_byte("sweep.const", out, 8'(2 * i + 1));
    end

    // Carry boundaries.
    step("wrap_ff_01", 1'b0, 1'b1, 8'hFF, 8'h01, 1'b0);
    check_bit("wrap_ff_01.cout_const", cout, 1'b1);
    step("max_ff_ff_1", 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
    check_byte("max_ff_ff_1.out_const", out, 8'hFF);
    step("cin_only", 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
    check_byte("cin_only.out_const", out, 8'h01);

    // Valid gating: result holds while operands change with in_valid low.
    step("gate_accept", 1'b0, 1'b1, 8'h10, 8'h20, 1'b0);
    step("gate_hold0", 1'b0, 1'b0, 8'hC3, 8'h77, 1'b1);
    check_byte("gate_hold0.out_const", out, 8'h30);
    step("gate_hold1", 1'b0, 1'b0, 8'h5A, 8'h99, 1'b0);

    // Reset wins over a valid input on the same edge.
    step("pre_reset", 1'b0, 1'b1, 8'h44, 8'h22, 1'b0);
    step("reset_mid", 1'b1, 1'b1, 8'h7F, 8'h01, 1'b0);
    step("after_reset", 1'b0, 1'b1, 8'h03, 8'h04, 1'b0);

    // Signed-overflow vectors (ovf compared only when the feature is built).
    step("ovf_7f_01", 1'b0, 1'b1, 8'h7F, 8'h01, 1'b0);
    step("ovf_80_80", 1'b0, 1'b1, 8'h80, 8'h80, 1'b0);
    step("ovf_05_fb", 1'b0, 1'b1, 8'h05, 8'hFB, 1'b0);
    step("ovf_hold", 1'b0, 1'b0, 8'h7F, 8'h7F, 1'b0);
    step("ovf_neg_cin", 1'b0, 1'b1, 8'h7F, 8'h00, 1'b1);

    // Random traffic with sparse valid drops and occasional resets.
    for (int k = 0; k < 300; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      step("random", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           ra, rb, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_adder_8bit
